// File: rtl/nn_pkg.sv
// Shared definitions for the activation-vector datapath.
// Holds the activation width, the default fan-in, the neuron pipeline
// latency, the activation type and the loader FSM state encoding.
package nn_pkg;

  localparam int ACT_W        = 16;  // activation width, two's complement
  localparam int N_IN_DEFAULT = 10;  // default neuron fan-in
  localparam int NODE_LAT     = 3;   // input reg + sum reg + ReLU reg
  localparam int HOLD_DEFAULT = 3;   // default minimum bank hold time

  typedef logic signed [ACT_W-1:0] act_t;

  typedef enum logic [1:0] {
    FILL = 2'd0,  // collecting samples into the shadow buffer
    WAIT = 2'd1,  // shadow full, waiting for the active bank hold to expire
    XFER = 2'd2   // copying shadow into the active bank
  } load_state_t;

endpackage

// File: rtl/act_vector_loader_if.sv
// Serial activation stream: valid/ready handshake carrying one signed
// activation per transfer, with s_last marking the final sample of a frame.
//   master : producer side (drives s_valid, s_data, s_last; reads s_ready)
//   slave  : loader side   (reads s_valid, s_data, s_last; drives s_ready)
interface act_vector_loader_if
  import nn_pkg::*;
#(
  parameter int W = ACT_W
);

  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/act_lat_pipe.sv
// LAT-deep single-bit delay line. A pulse on din appears on dout exactly LAT
// cycles later; back-to-back pulses stay separate. Used to turn the vector
// strobe into the result-valid tag matching the neuron pipeline latency.
//   clk, reset : clock, synchronous active-high reset (clears every stage)
//   din        : pulse in
//   dout       : pulse out, LAT cycles later
module act_lat_pipe
  import nn_pkg::*;
#(
  parameter int LAT = NODE_LAT  // must be >= 1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      logic stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (reset) stage_reg <= 1'b0;
          else       stage_reg <= din;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (reset) stage_reg <= 1'b0;
          else       stage_reg <= g_stage[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[LAT-1].stage_reg;

endmodule

// File: rtl/act_vector_loader.sv
// Producer end of the parallel activation interface. Serial activations are
// collected into a shadow buffer; each correctly framed vector is copied into
// a held output bank, announced by vec_strobe, and tagged LAT cycles later by
// res_valid when the downstream neurons have produced their outputs.
//   clk, reset : clock, synchronous active-high reset
//   s          : serial activation stream (slave side)
//   vec_out    : active bank, element k at [k*W +: W]
//   vec_strobe : one-cycle pulse while the freshly loaded bank is first visible
//   res_valid  : one-cycle pulse LAT cycles after vec_strobe
//   frame_err  : one-cycle pulse after a mis-framed sample is accepted
//   frame_cnt  : number of vectors transferred, wraps at 16 bits
module act_vector_loader
  import nn_pkg::*;
#(
  parameter int N_IN = N_IN_DEFAULT,  // must be >= 2
  parameter int W    = ACT_W,
  parameter int HOLD = HOLD_DEFAULT,
  parameter int LAT  = NODE_LAT
) (
  input  logic              clk,
  input  logic              reset,
  act_vector_loader_if.slave s,
  output logic [N_IN*W-1:0] vec_out,
  output logic              vec_strobe,
  output logic              res_valid,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int IDX_W  = $clog2(N_IN);
  localparam int HOLD_W = $clog2(HOLD + 2);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_IN - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD);

  load_state_t       state_reg, state_next;
  logic [IDX_W-1:0]  wr_idx_reg, wr_idx_next;
  logic              shadow_full_reg, shadow_full_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next, hold_dec;
  logic [15:0]       frame_cnt_reg, frame_cnt_next;
  logic              strobe_reg, strobe_next;
  logic              frame_err_reg, frame_err_next;
  logic              accept, xfer;

  logic [W-1:0] shadow   [N_IN];
  logic [W-1:0] bank_reg [N_IN];

  assign s.s_ready = !reset && !shadow_full_reg;
  assign accept    = s.s_valid && s.s_ready;

  // Saturating decrement, applied every cycle unless XFER reloads it.
  assign hold_dec = (hold_cnt_reg != '0) ? hold_cnt_reg - 1'b1 : hold_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FILL;
      wr_idx_reg      <= '0;
      shadow_full_reg <= 1'b0;
      hold_cnt_reg    <= '0;
      frame_cnt_reg   <= '0;
      strobe_reg      <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wr_idx_reg      <= wr_idx_next;
      shadow_full_reg <= shadow_full_next;
      hold_cnt_reg    <= hold_cnt_next;
      frame_cnt_reg   <= frame_cnt_next;
      strobe_reg      <= strobe_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    wr_idx_next      = wr_idx_reg;
    shadow_full_next = shadow_full_reg;
    hold_cnt_next    = hold_dec;
    frame_cnt_next   = frame_cnt_reg;
    strobe_next      = 1'b0;
    frame_err_next   = 1'b0;
    xfer             = 1'b0;

    case (state_reg)
      FILL: begin
        if (accept) begin
          if (wr_idx_reg == LAST_IDX) begin
            wr_idx_next = '0;
            if (s.s_last) begin
              shadow_full_next = 1'b1;
              state_next       = WAIT;
            end else begin
              frame_err_next = 1'b1;  // frame too long: no s_last on last slot
            end
          end else if (s.s_last) begin
            wr_idx_next    = '0;      // frame too short: drop partial contents
            frame_err_next = 1'b1;
          end else begin
            wr_idx_next = wr_idx_reg + 1'b1;
          end
        end
      end

      // Leave WAIT once the hold time will have expired by the XFER cycle;
      // even with the hold already expired WAIT lasts one cycle, so the
      // last-sample to bank-update delay is always two cycles.
      WAIT: begin
        if (hold_dec == '0) state_next = XFER;
      end

      XFER: begin
        xfer             = 1'b1;
        hold_cnt_next    = HOLD_LOAD;
        frame_cnt_next   = frame_cnt_reg + 16'd1;
        shadow_full_next = 1'b0;
        strobe_next      = 1'b1;
        state_next       = FILL;
      end

      default: state_next = FILL;
    endcase
  end

  // Shadow buffer has no reset: wr_idx restarting at 0 discards stale data.
  always_ff @(posedge clk) begin
    if (accept) shadow[wr_idx_reg] <= s.s_data;
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_IN; k++) begin
      if (reset)     bank_reg[k] <= '0;
      else if (xfer) bank_reg[k] <= shadow[k];
    end
  end

  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_pack
      assign vec_out[gi*W +: W] = bank_reg[gi];
    end
  endgenerate

  act_lat_pipe #(.LAT(LAT)) u_lat_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (strobe_reg),
    .dout  (res_valid)
  );

  assign vec_strobe = strobe_reg;
  assign frame_err  = frame_err_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_act_vector_loader.sv
module tb_act_vector_loader;
  import nn_pkg::*;

  localparam int N  = 10;
  localparam int VW = N * ACT_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  act_vector_loader_if #(.W(ACT_W)) ifa ();
  act_vector_loader_if #(.W(ACT_W)) ifh ();

  logic [VW-1:0] vec_a, vec_h;
  logic          strobe_a, rv_a, err_a, strobe_h, rv_h, err_h;
  logic [15:0]   cnt_a, cnt_h;

  act_vector_loader #(.N_IN(N), .W(ACT_W), .HOLD(3), .LAT(NODE_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (ifa),
    .vec_out    (vec_a),
    .vec_strobe (strobe_a),
    .res_valid  (rv_a),
    .frame_err  (err_a),
    .frame_cnt  (cnt_a)
  );

  act_vector_loader #(.N_IN(N), .W(ACT_W), .HOLD(20), .LAT(NODE_LAT)) dut_h (
    .clk        (clk),
    .reset      (reset),
    .s          (ifh),
    .vec_out    (vec_h),
    .vec_strobe (strobe_h),
    .res_valid  (rv_h),
    .frame_err  (err_h),
    .frame_cnt  (cnt_h)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Event log: cycle stamps of output pulses, observed mid-cycle.
  int cyc = 0;
  int str_a[$], rva_q[$], erra_q[$], str_h[$], rvh_q[$];
  int stall_a = 0, stall_h = 0, acc_h = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ifa.s_valid && !ifa.s_ready) stall_a <= stall_a + 1;
    if (ifh.s_valid && !ifh.s_ready) stall_h <= stall_h + 1;
    if (ifh.s_valid && ifh.s_ready)  acc_h   <= acc_h + 1;
  end

  always @(negedge clk) begin
    if (strobe_a) begin
      str_a.push_back(cyc);
      $display("transfer dut=a cycle=%0d frame_cnt=%0d", cyc, cnt_a);
    end
    if (rv_a)  rva_q.push_back(cyc);
    if (err_a) erra_q.push_back(cyc);
    if (strobe_h) begin
      str_h.push_back(cyc);
      $display("transfer dut=h cycle=%0d frame_cnt=%0d", cyc, cnt_h);
    end
    if (rv_h) rvh_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [15:0] first, input logic [15:0] stp);
    logic [VW-1:0] v;
    logic [15:0]   e;
    v = '0;
    e = first;
    for (int k = 0; k < N; k++) begin
      v[k*ACT_W +: ACT_W] = e;
      e = e + stp;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until the handshake fires (bounded).
  task automatic send(input bit sel, input act_t d, input bit last);
    bit rdy;
    int t;
    if (sel) begin ifh.s_valid = 1'b1; ifh.s_data = d; ifh.s_last = last; end
    else     begin ifa.s_valid = 1'b1; ifa.s_data = d; ifa.s_last = last; end
    rdy = 1'b0;
    t   = 0;
    while (!rdy && t < 100) begin
      rdy = sel ? ifh.s_ready : ifa.s_ready;
      step();
      t++;
    end
    chk("handshake", VW'(rdy), VW'(1));
  endtask

  task automatic idle_in(input bit sel);
    if (sel) begin ifh.s_valid = 1'b0; ifh.s_data = 16'hDEAD; ifh.s_last = 1'b0; end
    else     begin ifa.s_valid = 1'b0; ifa.s_data = 16'hDEAD; ifa.s_last = 1'b0; end
  endtask

  task automatic send_frame(input bit sel, input int n, input logic [15:0] first,
                            input logic [15:0] stp, input int last_pos, input bit drop);
    logic [15:0] d;
    d = first;
    for (int k = 0; k < n; k++) begin
      send(sel, act_t'(d), (k == last_pos));
      d = d + stp;
    end
    if (drop) idle_in(sel);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  int bs, br, be, st0, acc0;

  initial begin
    idle_in(1'b0);
    idle_in(1'b1);
    step();
    step();

    // Reset state
    chk("rst_s_ready", VW'(ifa.s_ready), VW'(0));
    chk("rst_vec_out", vec_a, '0);
    chk("rst_strobe", VW'(strobe_a), VW'(0));
    chk("rst_res_valid", VW'(rv_a), VW'(0));
    chk("rst_frame_err", VW'(err_a), VW'(0));
    chk("rst_frame_cnt", VW'(cnt_a), VW'(0));
    reset = 1'b0;
    step();
    chk("post_rst_s_ready", VW'(ifa.s_ready), VW'(1));

    // Single frame 1..10: bank updates 2 cycles after the last accept,
    // res_valid 3 cycles after the strobe.
    send_frame(1'b0, 10, 16'd1, 16'd1, 9, 1'b1);
    chk("t1_ready_wait", VW'(ifa.s_ready), VW'(0));
    chk("t1_vec_early0", vec_a, '0);
    step();
    chk("t1_vec_early1", vec_a, '0);
    chk("t1_ready_xfer", VW'(ifa.s_ready), VW'(0));
    chk("t1_strobe_early", VW'(strobe_a), VW'(0));
    step();
    chk("t1_vec", vec_a, mkvec(16'd1, 16'd1));
    chk("t1_strobe", VW'(strobe_a), VW'(1));
    chk("t1_frame_cnt", VW'(cnt_a), VW'(1));
    chk("t1_ready_back", VW'(ifa.s_ready), VW'(1));
    step();
    chk("t1_strobe_end", VW'(strobe_a), VW'(0));
    chk("t1_rv_lat1", VW'(rv_a), VW'(0));
    step();
    chk("t1_rv_lat2", VW'(rv_a), VW'(0));
    step();
    chk("t1_rv_lat3", VW'(rv_a), VW'(1));
    step();
    chk("t1_rv_end", VW'(rv_a), VW'(0));

    // Back-to-back frames 1..10 then -1..-10
    do_reset();
    bs = str_a.size(); br = rva_q.size(); st0 = stall_a;
    send_frame(1'b0, 10, 16'd1, 16'd1, 9, 1'b0);
    send_frame(1'b0, 10, 16'hFFFF, 16'hFFFF, 9, 1'b1);
    repeat (10) step();
    chk("t2_stall_cycles", VW'(stall_a - st0), VW'(2));
    chk("t2_strobe_count", VW'(str_a.size() - bs), VW'(2));
    chk("t2_period", VW'(str_a[bs+1] - str_a[bs]), VW'(12));
    chk("t2_rv_count", VW'(rva_q.size() - br), VW'(2));
    chk("t2_rv0_lat", VW'(rva_q[br] - str_a[bs]), VW'(3));
    chk("t2_rv1_lat", VW'(rva_q[br+1] - str_a[bs+1]), VW'(3));
    chk("t2_vec_neg", vec_a, mkvec(16'hFFFF, 16'hFFFF));
    chk("t2_frame_cnt", VW'(cnt_a), VW'(2));

    // s_last on the 4th sample
    do_reset();
    send_frame(1'b0, 10, 16'd1, 16'd1, 9, 1'b1);
    repeat (6) step();
    be = erra_q.size(); bs = str_a.size();
    send_frame(1'b0, 4, 16'd50, 16'd1, 3, 1'b1);
    chk("t4_err_pulse", VW'(err_a), VW'(1));
    chk("t4_ready", VW'(ifa.s_ready), VW'(1));
    step();
    chk("t4_err_end", VW'(err_a), VW'(0));
    chk("t4_vec_kept", vec_a, mkvec(16'd1, 16'd1));
    chk("t4_cnt_kept", VW'(cnt_a), VW'(1));
    send_frame(1'b0, 10, 16'd200, 16'd1, 9, 1'b1);
    repeat (8) step();
    chk("t4_vec_clean", vec_a, mkvec(16'd200, 16'd1));
    chk("t4_cnt_clean", VW'(cnt_a), VW'(2));
    chk("t4_err_count", VW'(erra_q.size() - be), VW'(1));
    chk("t4_strobe_count", VW'(str_a.size() - bs), VW'(1));

    // Ten samples without s_last
    be = erra_q.size(); bs = str_a.size();
    send_frame(1'b0, 10, 16'd300, 16'd1, -1, 1'b1);
    chk("t5_err_pulse", VW'(err_a), VW'(1));
    step();
    chk("t5_err_end", VW'(err_a), VW'(0));
    repeat (8) step();
    chk("t5_no_strobe", VW'(str_a.size() - bs), VW'(0));
    chk("t5_err_count", VW'(erra_q.size() - be), VW'(1));
    chk("t5_vec_kept", vec_a, mkvec(16'd200, 16'd1));
    chk("t5_cnt_kept", VW'(cnt_a), VW'(2));

    // Reset on the 6th sample of a frame
    be = erra_q.size();
    send_frame(1'b0, 5, 16'd400, 16'd1, -1, 1'b0);
    ifa.s_data = 16'd405;
    reset = 1'b1;
    step();
    chk("t6_rst_vec", vec_a, '0);
    chk("t6_rst_cnt", VW'(cnt_a), VW'(0));
    chk("t6_rst_ready", VW'(ifa.s_ready), VW'(0));
    idle_in(1'b0);
    reset = 1'b0;
    step();
    send_frame(1'b0, 10, 16'd500, 16'd1, 9, 1'b1);
    repeat (8) step();
    chk("t6_vec_after", vec_a, mkvec(16'd500, 16'd1));
    chk("t6_cnt_after", VW'(cnt_a), VW'(1));
    chk("t6_no_err", VW'(erra_q.size() - be), VW'(0));

    // Reset while res_valid is pending
    bs = str_a.size(); br = rva_q.size();
    send_frame(1'b0, 10, 16'd600, 16'd1, 9, 1'b1);
    step();
    step();
    chk("t6_pend_strobe", VW'(strobe_a), VW'(1));
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (6) step();
    chk("t6_pend_strobes", VW'(str_a.size() - bs), VW'(1));
    chk("t6_pend_no_rv", VW'(rva_q.size() - br), VW'(0));
    chk("t6_pend_vec", vec_a, '0);
    chk("t6_pend_cnt", VW'(cnt_a), VW'(0));

    // HOLD=20 instance, three frames back-to-back
    do_reset();
    bs = str_h.size(); br = rvh_q.size(); st0 = stall_h; acc0 = acc_h;
    send_frame(1'b1, 10, 16'd1, 16'd1, 9, 1'b0);
    send_frame(1'b1, 10, 16'h8000, 16'd1, 9, 1'b0);
    send_frame(1'b1, 10, 16'd100, 16'd1, 9, 1'b1);
    repeat (30) step();
    chk("t3_strobe_count", VW'(str_h.size() - bs), VW'(3));
    chk("t3_period_ab", VW'(str_h[bs+1] - str_h[bs]), VW'(21));
    chk("t3_period_bc", VW'(str_h[bs+2] - str_h[bs+1]), VW'(21));
    chk("t3_stall_cycles", VW'(stall_h - st0), VW'(13));
    chk("t3_accepts", VW'(acc_h - acc0), VW'(30));
    chk("t3_rv_count", VW'(rvh_q.size() - br), VW'(3));
    chk("t3_vec", vec_h, mkvec(16'd100, 16'd1));
    chk("t3_frame_cnt", VW'(cnt_h), VW'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
